// File: rtl/aoi_bist_pkg.sv
// Shared state encoding, last-vector constant and golden AOI function
// for the AOI cell self-test sequencer.
package aoi_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } aoi_bist_state_t;

    localparam logic [2:0] VEC_LAST = 3'd7;

    function automatic logic aoi_expected(input logic [2:0] v);
        return ~((v[2] & v[1]) | v[0]);
    endfunction

endpackage

// File: rtl/aoi_bist_controller.sv
// Self-test sequencer for one AND-OR-Inverter cell: walks all eight {a,b,c}
// vectors, waits SETTLE_CYCLES per vector, and records mismatches.
module aoi_bist_controller
    import aoi_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       aoi_a,
    output logic       aoi_b,
    output logic       aoi_c,
    input  logic       aoi_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail_vec
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    aoi_bist_state_t state_r, state_s;
    logic [2:0]      vec_r, vec_s;
    logic [3:0]      settle_cnt_r, settle_cnt_s;
    logic [3:0]      err_count_r, err_count_s;
    logic            fail_valid_r, fail_valid_s;
    logic [2:0]      first_fail_vec_r, first_fail_vec_s;
    logic            pass_r, pass_s;
    logic            mismatch_s;
    logic            busy_r;
    logic            done_r;
    logic [2:0]      pins_r;

    // Next-state, vector stepping and result bookkeeping.
    always_comb begin
        state_s          = state_r;
        vec_s            = vec_r;
        settle_cnt_s     = settle_cnt_r;
        err_count_s      = err_count_r;
        fail_valid_s     = fail_valid_r;
        first_fail_vec_s = first_fail_vec_r;
        pass_s           = pass_r;
        mismatch_s       = (aoi_y != aoi_expected(vec_r));
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s          = SETTLE;
                    vec_s            = 3'd0;
                    settle_cnt_s     = 4'd0;
                    err_count_s      = 4'd0;
                    fail_valid_s     = 1'b0;
                    first_fail_vec_s = 3'd0;
                    pass_s           = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                settle_cnt_s = settle_cnt_r + 4'd1;
                if (abort) begin
                    state_s = IDLE;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = CHECK;
                end else begin
                    state_s = SETTLE;
                end
            end
            CHECK: begin
                // An aborting check cycle leaves the partial results untouched.
                if (abort) begin
                    state_s = IDLE;
                end else begin
                    if (mismatch_s) begin
                        err_count_s = err_count_r + 4'd1;
                        if (!fail_valid_r) begin
                            fail_valid_s     = 1'b1;
                            first_fail_vec_s = vec_r;
                        end else begin
                            first_fail_vec_s = first_fail_vec_r;
                        end
                    end else begin
                        err_count_s = err_count_r;
                    end
                    if (vec_r == VEC_LAST) begin
                        state_s = DONE;
                        pass_s  = (err_count_s == 4'd0);
                    end else begin
                        state_s      = SETTLE;
                        vec_s        = vec_r + 3'd1;
                        settle_cnt_s = 4'd0;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and result registers; status and pin outputs registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            vec_r            <= 3'd0;
            settle_cnt_r     <= 4'd0;
            err_count_r      <= 4'd0;
            fail_valid_r     <= 1'b0;
            first_fail_vec_r <= 3'd0;
            pass_r           <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pins_r           <= 3'd0;
        end else begin
            state_r          <= state_s;
            vec_r            <= vec_s;
            settle_cnt_r     <= settle_cnt_s;
            err_count_r      <= err_count_s;
            fail_valid_r     <= fail_valid_s;
            first_fail_vec_r <= first_fail_vec_s;
            pass_r           <= pass_s;
            busy_r           <= (state_s == SETTLE) || (state_s == CHECK);
            done_r           <= (state_s == DONE);
            pins_r           <= ((state_s == SETTLE) || (state_s == CHECK)) ? vec_s : 3'd0;
        end
    end

    assign aoi_a          = pins_r[2];
    assign aoi_b          = pins_r[1];
    assign aoi_c          = pins_r[0];
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_count      = err_count_r;
    assign fail_valid     = fail_valid_r;
    assign first_fail_vec = first_fail_vec_r;

endmodule

// File: tb/tb_aoi_bist_controller.sv
// Scoreboard bench: two controllers (settle 1 and 3) each driving a behavioural
// AOI cell with selectable faults, checked against a vector-level reference model.
module tb_aoi_bist_controller;

    localparam int NI = 2;

    typedef struct {
        int err;
        bit fv;
        int ffv;
        bit pass;
    } res_t;

    logic clk = 1'b0;
    logic rst_v   [NI] = '{1'b1, 1'b1};
    logic start_v [NI] = '{1'b0, 1'b0};
    logic abort_v [NI] = '{1'b0, 1'b0};
    logic a_v [NI], b_v [NI], c_v [NI], y_v [NI];
    logic busy_v [NI], done_v [NI], pass_v [NI], fv_v [NI];
    logic [3:0] err_v [NI];
    logic [2:0] ffv_v [NI];

    int   gate_mode [NI] = '{0, 0};
    int   fault_vec [NI] = '{0, 0};
    int   cyc = 0;
    int   acc_cyc [NI] = '{0, 0};
    int   end_cyc [NI] = '{-1, -1};
    bit   nodone  [NI] = '{1'b0, 1'b0};
    res_t q [NI][$];
    res_t last_exp [NI];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Cell fault models: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 non-inverting, 4 one flipped vector
    function automatic logic gate_y(input int mode, input int fvec, input logic [2:0] p);
        logic good;
        good = ~((p[2] & p[1]) | p[0]);
        case (mode)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ~good;
            4:       return (int'(p) == fvec) ? ~good : good;
            default: return good;
        endcase
    endfunction

    // Results expected from all checks whose sampling edge precedes 'cut'
    function automatic res_t model(input int mode, input int fvec, input int s, input int acc, input int cut);
        res_t r;
        r.err = 0; r.fv = 1'b0; r.ffv = 0; r.pass = 1'b0;
        for (int v = 0; v < 8; v++) begin
            bit   want;
            logic got;
            if (acc + (v + 1) * (s + 1) < cut) begin
                want = (v == 0) || (v == 2) || (v == 4);
                got  = gate_y(mode, fvec, 3'(v));
                if (got != want) begin
                    if (!r.fv) r.ffv = v;
                    r.fv = 1'b1;
                    r.err++;
                end
            end
        end
        r.pass = (cut > acc + 8 * (s + 1)) && (r.err == 0);
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aoi_bist_controller #(.SETTLE_CYCLES((g == 0) ? 1 : 3)) dut (
            .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .abort(abort_v[g]),
            .aoi_a(a_v[g]), .aoi_b(b_v[g]), .aoi_c(c_v[g]), .aoi_y(y_v[g]),
            .busy(busy_v[g]), .done(done_v[g]), .pass(pass_v[g]),
            .err_count(err_v[g]), .fail_valid(fv_v[g]), .first_fail_vec(ffv_v[g])
        );
        assign y_v[g] = gate_y(gate_mode[g], fault_vec[g], {a_v[g], b_v[g], c_v[g]});
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    // Monitor: per-cycle status/pin checks, pops the scoreboard when a result is presented
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int s;
            s = s_of(i);
            if (cyc >= acc_cyc[i] && cyc < end_cyc[i]) begin
                chk($sformatf("dut%0d busy", i), 32'(busy_v[i]), 32'd1);
                chk($sformatf("dut%0d done", i), 32'(done_v[i]), 32'd0);
                chk($sformatf("dut%0d pins", i), 32'({a_v[i], b_v[i], c_v[i]}),
                    32'((cyc - acc_cyc[i]) / (s + 1)));
            end else begin
                chk($sformatf("dut%0d busy", i), 32'(busy_v[i]), 32'd0);
                chk($sformatf("dut%0d pins", i), 32'({a_v[i], b_v[i], c_v[i]}), 32'd0);
                chk($sformatf("dut%0d done", i), 32'(done_v[i]),
                    32'((cyc == end_cyc[i]) && !nodone[i]));
                if (done_v[i] === 1'b1 || (cyc == end_cyc[i] && nodone[i])) begin
                    if (q[i].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut%0d scoreboard at cycle %0d: got a result, expected none", i, cyc);
                    end else begin
                        last_exp[i] = q[i].pop_front();
                    end
                end
                chk($sformatf("dut%0d pass", i), 32'(pass_v[i]), 32'(last_exp[i].pass));
                chk($sformatf("dut%0d err_count", i), 32'(err_v[i]), 32'(last_exp[i].err));
                chk($sformatf("dut%0d fail_valid", i), 32'(fv_v[i]), 32'(last_exp[i].fv));
                if (last_exp[i].fv)
                    chk($sformatf("dut%0d first_fail_vec", i), 32'(ffv_v[i]), 32'(last_exp[i].ffv));
            end
        end
    end

    // One run on instance i; cut_off>0 aborts (or resets) at edge acc+cut_off
    task automatic run(input int i, input int mode, input int fvec, input int cut_off,
                       input bit by_rst, input logic [63:0] junk, input bit done_start);
        int   s, len, acc, cut;
        res_t r;
        s   = s_of(i);
        len = 8 * (s + 1);
        @(negedge clk);
        gate_mode[i] = mode;
        fault_vec[i] = fvec;
        acc = cyc + 1;
        cut = (cut_off > 0) ? acc + cut_off : acc + len + 1;
        if (by_rst) begin
            r.err = 0; r.fv = 1'b0; r.ffv = 0; r.pass = 1'b0;
        end else begin
            r = model(mode, fvec, s, acc, cut);
        end
        q[i].push_back(r);
        acc_cyc[i] = acc;
        end_cyc[i] = (cut_off > 0) ? acc + cut_off : acc + len;
        nodone[i]  = (cut_off > 0);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        while (cyc < end_cyc[i]) begin
            int off;
            off = cyc - acc + 1;
            if (off < 64) start_v[i] = junk[off];
            if (cut_off > 0 && off == cut_off) begin
                if (by_rst) rst_v[i] = 1'b1;
                else abort_v[i] = 1'b1;
            end
            @(negedge clk);
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            rst_v[i]   = 1'b0;
        end
        if (!nodone[i] && done_start) begin
            start_v[i] = 1'b1;
            @(negedge clk);
            start_v[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            last_exp[i].err = 0; last_exp[i].fv = 1'b0; last_exp[i].ffv = 0; last_exp[i].pass = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        run(0, 0, 0, 0, 1'b0, 64'h0, 1'b0);
        run(0, 1, 0, 0, 1'b0, 64'h0, 1'b0);
        run(0, 3, 0, 0, 1'b0, 64'h0, 1'b0);
        run(1, 0, 0, 0, 1'b0, 64'h0, 1'b0);
        run(0, 0, 0, 0, 1'b0, 64'h420, 1'b1);
        run(0, 2, 0, 6, 1'b0, 64'h0, 1'b0);
        run(0, 2, 0, 6, 1'b1, 64'h0, 1'b0);
        run(1, 2, 0, 13, 1'b0, 64'h2000, 1'b0);
        run(0, 4, 7, 16, 1'b0, 64'h0, 1'b0);
        for (int n = 0; n < 24; n++) begin
            int  i, len, off;
            bit  br;
            i   = int'($urandom_range(1, 0));
            len = 8 * (s_of(i) + 1);
            off = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 1)) : 0;
            br  = (off > 0) && ($urandom_range(2, 0) == 0);
            run(i, int'($urandom_range(4, 0)), int'($urandom_range(7, 0)), off, br,
                {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
                1'($urandom_range(1, 0)));
        end
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
